// File: rtl/subtractor_32bit_serial.sv
// Bit-serial (slice-serial) unsigned subtractor: diff = a - b mod 2^WIDTH, one SLICE per clock,
// LSB slice first, with valid/ready handshakes on both sides.
module subtractor_32bit_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned IW     = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic              in_ready_nx, out_valid_nx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [CW-1:0]     cnt;
  logic              bin;
  logic              accept_c, last_c;
  logic [IW-1:0]     lo_c;
  logic [SLICE:0]    sub_c;

  assign accept_c = (state == IDLE) && in_valid;
  assign last_c   = (cnt == CW'(NSLICE - 1));
  assign lo_c     = IW'(cnt) * IW'(SLICE);

  // One slice of subtraction at SLICE+1 bits; the top bit is the slice borrow-out.
  assign sub_c = {1'b0, a_q[lo_c +: SLICE]} - {1'b0, b_q[lo_c +: SLICE]} - (SLICE+1)'(bin);

  // State and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_c)    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_nx  = 1'b0;
    out_valid_nx = 1'b0;
    if (state_nx == IDLE) in_ready_nx  = 1'b1;
    if (state_nx == DONE) out_valid_nx = 1'b1;
  end

  // Operand capture and slice datapath; diff/borrow hold their value outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept_c) begin
      a_q <= a;
      b_q <= b;
      cnt <= '0;
      bin <= 1'b0;
    end else if (state == RUN) begin
      diff[lo_c +: SLICE] <= sub_c[SLICE-1:0];
      bin                 <= sub_c[SLICE];
      cnt                 <= last_c ? '0 : cnt + CW'(1);
      if (last_c) borrow  <= sub_c[SLICE];
    end
  end

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
// Scoreboard bench for subtractor_32bit_serial: directed vectors, backpressure,
// asynchronous reset mid-operation and a randomised regression.
module tb_subtractor_32bit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;

  int errors = 0;
  int checks = 0;
  int ops_done = 0;
  int hs_cnt = 0;
  logic [32:0] sb[$];

  subtractor_32bit_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) hs_cnt++;

  // One full transaction; stall = cycles out_ready is held low once out_valid rises.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input int stall);
    logic [32:0] exp;
    logic [31:0] held;
    int          lat;
    a = op_a; b = op_b; in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    sb.push_back({op_a < op_b, op_a - op_b});
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_timeout in_ready=%b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (!out_valid) out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (lat !== 4 || out_valid !== 1'b1)
      begin errors++; $display("FAIL latency got=%0d cycles (out_valid=%b) required 4", lat, out_valid); end
    out_ready = 1'b0;
    held = diff;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== held || in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold out_valid=%b in_ready=%b diff=%h required 1/0/%h", out_valid, in_ready, diff, held); end
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 33'h0;
    checks++;
    if ({borrow, diff} !== exp)
      begin errors++; $display("FAIL result a=%h b=%h got diff=%h borrow=%b required diff=%h borrow=%b", op_a, op_b, diff, borrow, exp[31:0], exp[32]); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    ops_done++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL post_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || borrow !== 1'b0)
      begin errors++; $display("FAIL reset_state in_ready=%b out_valid=%b diff=%h borrow=%b required 1/0/0/0", in_ready, out_valid, diff, borrow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(32'h0000_0005, 32'h0000_0003, 0);
    run_op(32'h0000_0100, 32'h0000_0001, 0);
    run_op(32'h0000_0000, 32'h0000_0001, 0);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1);
  endtask

  task automatic test_backpressure();
    run_op(32'h1234_5678, 32'h0123_4567, 10);
  endtask

  task automatic test_async_reset();
    a = 32'h0000_0005; b = 32'h0000_0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 32'h0 || borrow !== 1'b0)
      begin errors++; $display("FAIL async_reset out_valid=%b in_ready=%b diff=%h borrow=%b required 0/1/0/0", out_valid, in_ready, diff, borrow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom;
      if (n % 10 == 0) rb = ra;
      run_op(ra, rb, $urandom_range(0, 3));
    end
  endtask

  task automatic test_accounting();
    checks++;
    if (hs_cnt !== ops_done || sb.size() != 0)
      begin errors++; $display("FAIL accounting handshakes=%0d pending=%0d required %0d/0", hs_cnt, sb.size(), ops_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_async_reset();
    test_random();
    test_accounting();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subtractor_32bit_serial.md
Name: subtractor_32bit_serial

Overview:
- Multi-cycle subtractor: the inverse of the hierarchical adder tree.
- Computes diff = a - b (mod 2^WIDTH) and a borrow-out flag.
- Processes one SLICE-bit byte per clock, LSB slice first, and carries the borrow between slices in a register.
- Sits in the arithmetic datapath next to the adder blocks; valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 32: operand and result width; must be an integer multiple of SLICE.
- SLICE, 8: bits subtracted per cycle.
- NSLICE = WIDTH/SLICE (localparam, default 4): must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  diff/borrow valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0.
  - Slice counter=0, internal borrow register=0, operand registers=0.
  - Takes effect immediately; an operation in flight is discarded with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. If in_valid=1 at a rising edge, latch a and b, clear the borrow register and slice counter, and go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0, out_valid=0. Each edge processes slice k = counter:
    - {bo, d} = a[k] - b[k] - bin, computed at SLICE+1 bits.
    - Write d into diff[k*SLICE +: SLICE].
    - bin <= bo; counter++.
    - On the edge that processes slice NSLICE-1: borrow <= bo, out_valid <= 1, go to DONE.
  - DONE: out_valid=1; diff and borrow are held stable. When out_ready=1 at an edge: out_valid <= 0, go to IDLE.
    - in_ready is 0 in DONE, so no new operand is accepted in the same cycle as the output handshake.
    - in_valid is ignored in RUN and DONE.
- Latency:
  - Accept edge T → out_valid high after edge T+NSLICE (4 cycles for the defaults).
  - Minimum issue interval is NSLICE+2 cycles (accept, NSLICE slices, output handshake).
- diff during RUN:
  - Partially updated; only meaningful while out_valid=1.
  - diff is not cleared between operations; the previous result stays visible until overwritten slice by slice.
- Operand isolation: a and b are latched at accept; input changes after the accept edge do not affect the result.
- Arithmetic:
  - Unsigned modulo-2^WIDTH; borrow is the final slice's borrow-out.
  - The result must equal the single-cycle (a - b) for all inputs, including wrap-around.
- out_ready held high in DONE: result is consumed on the first DONE edge, so out_valid is high for exactly one cycle.
- out_ready low: block stalls in DONE indefinitely and the outputs do not change.

Test Plan:
- Reset then a=32'h0000_0005, b=32'h0000_0003, out_ready=1 → diff=32'h0000_0002, borrow=0; out_valid rises exactly 4 cycles after accept and lasts 1 cycle.
- a=32'h0000_0100, b=32'h0000_0001 → diff=32'h0000_00FF, borrow=0. Borrow propagates from slice 0 into slice 1.
- a=32'h0000_0000, b=32'h0000_0001 → diff=32'hFFFF_FFFF, borrow=1. Borrow ripples through all 4 slices (wrap-around).
- Hold out_ready=0 for 10 cycles after a=32'h1234_5678, b=32'h0123_4567 → out_valid stays 1 with diff=32'h1111_1111 stable.
  - in_valid=1 with new operands is ignored (in_ready=0).
  - After out_ready=1 for one edge, out_valid=0 and in_ready=1.
- Assert rst_n=0 asynchronously in mid-RUN (after 2 slices) → out_valid=0, in_ready=1, diff=0 immediately.
  - After release, a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → diff=0, borrow=0.
- Random regression of 1000 operand pairs with random out_ready backpressure → every result matches a reference (a-b, a<b). No result is lost or duplicated.
